// File: rtl/subtractor_4bit_if.sv
// Operand/result bundle for subtractor_4bit.
// Optional macro SUB_OVF_EN adds the registered signed-overflow flag OVF.
interface subtractor_4bit_if #(
    parameter int WIDTH = 4
);
    // Handshake: in_valid qualifies A/B/Bin at a rising clk edge; there is no ready,
    // so every valid operand set is accepted. out_valid is high for exactly the cycle
    // after an accepted edge, and D/Bout (and OVF) hold their value otherwise.
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             out_valid;
`ifdef SUB_OVF_EN
    logic             OVF;

    modport master (output in_valid, A, B, Bin, input D, Bout, out_valid, OVF);
    modport slave  (input in_valid, A, B, Bin, output D, Bout, out_valid, OVF);
`else
    modport master (output in_valid, A, B, Bin, input D, Bout, out_valid);
    modport slave  (input in_valid, A, B, Bin, output D, Bout, out_valid);
`endif
endinterface

// File: rtl/subtractor_4bit.sv
// Registered ripple-borrow subtractor: {Bout,D} = A - B - Bin, one cycle latency.
// Optional macro SUB_OVF_EN adds a registered signed-overflow flag (OVF).
module subtractor_4bit #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    subtractor_4bit_if.slave   bus
);
    logic [WIDTH-1:0] diff;
    logic [WIDTH:0]   borrow;
    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             out_valid_q;

    // Chain of 1-bit full subtractors; borrow[i] enters bit i.
    always_comb begin
        borrow    = '0;
        diff      = '0;
        borrow[0] = bus.Bin;
        for (int i = 0; i < WIDTH; i++) begin
            diff[i]       = bus.A[i] ^ bus.B[i] ^ borrow[i];
            borrow[i + 1] = (~bus.A[i] & bus.B[i]) | (~(bus.A[i] ^ bus.B[i]) & borrow[i]);
        end
    end

    // Result registers only load on in_valid, so junk on idle inputs cannot reach them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q         <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                d_q    <= diff;
                bout_q <= borrow[WIDTH];
            end
        end
    end

    assign bus.D         = d_q;
    assign bus.Bout      = bout_q;
    assign bus.out_valid = out_valid_q;

`ifdef SUB_OVF_EN
    logic ovf_next;
    logic ovf_q;

    // Signed overflow: operands differ in sign and the result sign differs from A.
    assign ovf_next = (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]) & (diff[WIDTH-1] ^ bus.A[WIDTH-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (bus.in_valid) begin
            ovf_q <= ovf_next;
        end
    end

    assign bus.OVF = ovf_q;
`endif
endmodule

// File: tb/tb_subtractor_4bit.sv
// Self-checking bench for subtractor_4bit against an integer-arithmetic reference model.
// Build with +define+SUB_OVF_EN to also check the OVF flag.
module tb_subtractor_4bit;
    localparam int W = 4;

    logic clk;
    logic rst_n;
    int   n_compared;
    int   n_mismatched;
    logic [W:0] exp_q[$];

    subtractor_4bit_if #(.WIDTH(W)) bus ();

    subtractor_4bit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    function automatic logic [W:0] ref_sub(input int a, input int b, input int bin);
        int r;
        r = a - b - bin;
        return r[W:0];
    endfunction

    function automatic logic ref_ovf(input int a, input int b, input int bin);
        int sa;
        int sb;
        int r;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        r  = sa - sb - bin;
        return (r < -8) || (r > 7);
    endfunction

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.Bin      = bin;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b1, 4'hF, 4'h0, 1'b0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        n_compared++;
        if ({bus.D, bus.Bout, bus.out_valid} !== 6'b0) begin
            n_mismatched++;
            $display("FAIL reset_initial: D=%b Bout=%b out_valid=%b expected all 0", bus.D, bus.Bout, bus.out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_compared++;
            if ({bus.D, bus.Bout, bus.out_valid} !== 6'b0) begin
                n_mismatched++;
                $display("FAIL reset_held_%0d: D=%b Bout=%b out_valid=%b expected all 0", i, bus.D, bus.Bout, bus.out_valid);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'h6, 4'h3, 1'b0);
        @(posedge clk); #1;
        n_compared++;
        if ({bus.D, bus.Bout, bus.out_valid} !== {4'h3, 1'b0, 1'b1}) begin
            n_mismatched++;
            $display("FAIL reset_release: D=%b Bout=%b out_valid=%b expected 0011 0 1", bus.D, bus.Bout, bus.out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_compared++;
        if ({bus.D, bus.Bout, bus.out_valid} !== 6'b0) begin
            n_mismatched++;
            $display("FAIL reset_async: D=%b Bout=%b out_valid=%b expected all 0", bus.D, bus.Bout, bus.out_valid);
        end
        @(posedge clk); #1;
        n_compared++;
        if ({bus.D, bus.Bout, bus.out_valid} !== 6'b0) begin
            n_mismatched++;
            $display("FAIL reset_discard: D=%b Bout=%b out_valid=%b expected all 0", bus.D, bus.Bout, bus.out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'h1, 4'h2, 1'b0);
        @(posedge clk); #1;
        n_compared++;
        if ({bus.D, bus.Bout, bus.out_valid} !== {4'hF, 1'b1, 1'b1}) begin
            n_mismatched++;
            $display("FAIL reset_first_after: D=%b Bout=%b out_valid=%b expected 1111 1 1", bus.D, bus.Bout, bus.out_valid);
        end
        drive(1'b0, 4'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ta[7];
        logic [W-1:0] tb[7];
        logic         tc[7];
        logic [W:0]   tx[7];
        ta = '{4'b0000, 4'b0001, 4'b1100, 4'b0000, 4'b0000, 4'b0110, 4'b1111};
        tb = '{4'b0000, 4'b0010, 4'b1110, 4'b0000, 4'b0011, 4'b0011, 4'b0011};
        tc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tx = '{5'b0_0000, 5'b1_1111, 5'b1_1110, 5'b1_1111, 5'b1_1100, 5'b0_0011, 5'b0_1100};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ta[i], tb[i], tc[i]);
            @(posedge clk); #1;
            n_compared++;
            if ({bus.Bout, bus.D, bus.out_valid} !== {tx[i], 1'b1}) begin
                n_mismatched++;
                $display("FAIL vector_%0d: Bout=%b D=%b out_valid=%b expected Bout,D=%b out_valid=1",
                         i, bus.Bout, bus.D, bus.out_valid, tx[i]);
            end
        end
        drive(1'b0, 4'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
        n_compared++;
        if (bus.out_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL b2b_drop_valid: out_valid=%b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_hold();
        drive(1'b1, 4'b0110, 4'b0011, 1'b0);
        @(posedge clk); #1;
        n_compared++;
        if ({bus.D, bus.Bout, bus.out_valid} !== {4'b0011, 1'b0, 1'b1}) begin
            n_mismatched++;
            $display("FAIL hold_load: D=%b Bout=%b out_valid=%b expected 0011 0 1", bus.D, bus.Bout, bus.out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                bus.in_valid = 1'b0;
                bus.A        = 'x;
                bus.B        = 'x;
                bus.Bin      = 1'bx;
            end else begin
                drive(1'b0, W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            end
            @(posedge clk); #1;
            n_compared++;
            if ({bus.D, bus.Bout, bus.out_valid} !== {4'b0011, 1'b0, 1'b0}) begin
                n_mismatched++;
                $display("FAIL hold_%0d: D=%b Bout=%b out_valid=%b expected 0011 0 0", i, bus.D, bus.Bout, bus.out_valid);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [W:0] exp;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    drive(1'b1, W'(a), W'(b), 1'(c));
                    exp_q.push_back(ref_sub(a, b, c));
                    @(posedge clk); #1;
                    exp = exp_q.pop_front();
                    n_compared++;
                    if ({bus.Bout, bus.D, bus.out_valid} !== {exp, 1'b1}) begin
                        n_mismatched++;
                        $display("FAIL exhaustive A=%0d B=%0d Bin=%0d: Bout,D=%b out_valid=%b expected %b 1",
                                 a, b, c, {bus.Bout, bus.D}, bus.out_valid, exp);
                    end
                end
            end
        end
        drive(1'b0, 4'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [W:0] last;
        logic       v;
        int         a;
        int         b;
        int         c;
        last = {bus.Bout, bus.D};
        for (int i = 0; i < 200; i++) begin
            v = 1'($urandom_range(0, 3) != 0);
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            c = int'($urandom_range(0, 1));
            drive(v, W'(a), W'(b), 1'(c));
            if (v) last = ref_sub(a, b, c);
            @(posedge clk); #1;
            n_compared++;
            if ({bus.Bout, bus.D, bus.out_valid} !== {last, v}) begin
                n_mismatched++;
                $display("FAIL random_%0d: Bout,D=%b out_valid=%b expected %b %b",
                         i, {bus.Bout, bus.D}, bus.out_valid, last, v);
            end
        end
        drive(1'b0, 4'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
    endtask

`ifdef SUB_OVF_EN
    task automatic test_ovf();
        logic last;
        int   a;
        int   b;
        int   c;
        logic v;
        drive(1'b1, 4'b1000, 4'b0001, 1'b0);
        @(posedge clk); #1;
        n_compared++;
        if ({bus.D, bus.OVF} !== {4'b0111, 1'b1}) begin
            n_mismatched++;
            $display("FAIL ovf_neg: D=%b OVF=%b expected 0111 1", bus.D, bus.OVF);
        end
        drive(1'b1, 4'b0111, 4'b1111, 1'b0);
        @(posedge clk); #1;
        n_compared++;
        if ({bus.D, bus.OVF} !== {4'b1000, 1'b1}) begin
            n_mismatched++;
            $display("FAIL ovf_pos: D=%b OVF=%b expected 1000 1", bus.D, bus.OVF);
        end
        drive(1'b1, 4'b0110, 4'b0011, 1'b0);
        @(posedge clk); #1;
        n_compared++;
        if ({bus.D, bus.OVF} !== {4'b0011, 1'b0}) begin
            n_mismatched++;
            $display("FAIL ovf_none: D=%b OVF=%b expected 0011 0", bus.D, bus.OVF);
        end
        last = 1'b0;
        for (int i = 0; i < 200; i++) begin
            v = 1'($urandom_range(0, 3) != 0);
            a = int'($urandom_range(0, 15));
            b = int'($urandom_range(0, 15));
            c = int'($urandom_range(0, 1));
            drive(v, W'(a), W'(b), 1'(c));
            if (v) last = ref_ovf(a, b, c);
            @(posedge clk); #1;
            n_compared++;
            if (bus.OVF !== last) begin
                n_mismatched++;
                $display("FAIL ovf_random_%0d: OVF=%b expected %b", i, bus.OVF, last);
            end
        end
        drive(1'b0, 4'h0, 4'h0, 1'b0);
        @(posedge clk); #1;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        test_reset();
        test_back_to_back();
        test_hold();
        test_exhaustive();
        test_random();
`ifdef SUB_OVF_EN
        test_ovf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
